// File: rtl/fadd_acc.sv
// Streaming float32 accumulator: folds each packet of operands into one total
// through a combinational round-to-nearest-even adder and returns it with sticky status.

module fadd (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res,
   output logic        ovf
);

   logic        a_nan, b_nan, a_inf, b_inf;
   logic        swap, sign_big, sub;
   logic [31:0] big, sml;
   logic [7:0]  ex_big, ex_sml, diff;
   logic [26:0] m_big, m_sml, m_sh, mask;
   logic        sticky;
   logic [27:0] sum;
   logic [26:0] norm;
   logic [9:0]  e, sh;
   logic [4:0]  lz;
   logic        rnd;
   logic [24:0] mant_r;
   logic [23:0] mant;

   assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

   // NOTE: every variable gets a default at the top of an always_comb block so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      res    = 32'd0;
      ovf    = 1'b0;
      swap   = (b[30:0] > a[30:0]);
      big    = swap ? b : a;
      sml    = swap ? a : b;
      sign_big = big[31];
      sub    = a[31] ^ b[31];
      // Denormals use an effective exponent of 1 and no hidden bit.
      ex_big = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      ex_sml = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      diff   = ex_big - ex_sml;
      m_big  = {(big[30:23] != 8'd0), big[22:0], 3'b000};
      m_sml  = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
      mask   = 27'd0;
      m_sh   = 27'd0;
      sticky = 1'b0;
      if (diff >= 8'd27) begin
         sticky = |m_sml;
      end else begin
         mask   = (27'd1 << diff) - 27'd1;
         sticky = |(m_sml & mask);
         m_sh   = m_sml >> diff;
      end
      m_sh[0] = m_sh[0] | sticky;

      sum  = sub ? ({1'b0, m_big} - {1'b0, m_sh}) : ({1'b0, m_big} + {1'b0, m_sh});
      e    = {2'b00, ex_big};
      lz   = 5'd27;
      sh   = 10'd0;
      norm = sum[26:0];
      if (sum[27]) begin
         norm = {sum[27:2], sum[1] | sum[0]};
         e    = e + 10'd1;
      end else begin
         for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
         end
         // Never normalise below the minimum exponent; the result stays denormal.
         sh   = ({5'd0, lz} > (e - 10'd1)) ? (e - 10'd1) : {5'd0, lz};
         norm = sum[26:0] << sh;
         e    = e - sh;
      end

      rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r = {1'b0, norm[26:3]} + {24'd0, rnd};
      mant   = mant_r[23:0];
      if (mant_r[24]) begin
         mant = mant_r[24:1];
         e    = e + 10'd1;
      end

      if (a_nan || b_nan) begin
         res = a_nan ? (a | 32'h0040_0000) : (b | 32'h0040_0000);
      end else if (a_inf && b_inf && sub) begin
         res = 32'h7FC0_0000;
      end else if (a_inf) begin
         res = a;
      end else if (b_inf) begin
         res = b;
      end else if (sum == 28'd0) begin
         // Exact cancellation gives +0; only -0 + -0 keeps the negative sign.
         res = {a[31] & b[31], 31'd0};
      end else if (e >= 10'd255) begin
         res = {sign_big, 8'hFF, 23'd0};
         ovf = 1'b1;
      end else begin
         res = {sign_big, (mant[23] ? e[7:0] : 8'd0), mant[22:0]};
      end
   end

endmodule

module fadd_acc #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             out_special
);

   typedef enum logic {ACC, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             special_q, special_d;
   logic [31:0]      add_res;
   logic             add_ovf;
   logic             accept;

   fadd u_fadd (
      .a   (acc_q),
      .b   (in_data),
      .res (add_res),
      .ovf (add_ovf)
   );

   assign accept = (state_q == ACC) && in_valid;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      special_d = special_q;
      unique case (state_q)
         ACC: begin
            if (accept) begin
               count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
               // The first beat is loaded verbatim so -0.0 and NaN payloads survive.
               if (count_q == '0) begin
                  acc_d     = in_data;
                  ovf_d     = 1'b0;
                  special_d = (in_data[30:23] == 8'hFF);
               end else begin
                  acc_d     = add_res;
                  ovf_d     = ovf_q | add_ovf;
                  special_d = special_q | (add_res[30:23] == 8'hFF);
               end
               if (in_last) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d   = ACC;
               acc_d     = 32'd0;
               count_d   = '0;
               ovf_d     = 1'b0;
               special_d = 1'b0;
            end
         end
         default: state_d = ACC;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its next-state value from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACC;
         acc_q     <= 32'd0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         special_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         special_q <= special_d;
      end
   end

   assign in_ready    = (state_q == ACC);
   assign out_valid   = (state_q == DONE);
   assign out_sum     = acc_q;
   assign out_count   = count_q;
   assign out_ovf     = ovf_q;
   assign out_special = special_q;

endmodule

// File: tb/tb_fadd_acc.sv
// Directed bench for fadd_acc: packet sums, rounding, specials, backpressure,
// mid-packet reset and counter saturation on a narrow-counter instance.

module tb_fadd_acc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_ready, out_valid, out_ovf, out_special;
   logic [31:0] out_sum;
   logic [15:0] out_count;

   logic        v2 = 1'b0, l2 = 1'b0, r2 = 1'b0;
   logic [31:0] d2 = 32'd0;
   logic        rdy2, ov2_valid, ovf2, sp2;
   logic [31:0] sum2;
   logic [1:0]  cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fadd_acc dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_ovf(out_ovf), .out_special(out_special)
   );

   fadd_acc #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_last(l2),
      .out_valid(ov2_valid), .out_ready(r2), .out_sum(sum2),
      .out_count(cnt2), .out_ovf(ovf2), .out_special(sp2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic finish_pkt(input string tag, input logic [31:0] e_sum, input logic [31:0] e_cnt,
                             input logic e_ovf, input logic e_sp);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_sum"}, out_sum, e_sum);
      check({tag, "_count"}, 32'(out_count), e_cnt);
      check({tag, "_ovf"}, 32'(out_ovf), 32'(e_ovf));
      check({tag, "_special"}, 32'(out_special), 32'(e_sp));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", out_sum, 32'd0);
      check("rst_count", 32'(out_count), 32'd0);
      check("rst_flags", {30'd0, out_ovf, out_special}, 32'd0);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      beat(32'h3F80_0000, 1'b0);
      check("sum_mid_valid", 32'(out_valid), 32'd0);
      beat(32'h4000_0000, 1'b0);
      beat(32'h4040_0000, 1'b1);
      finish_pkt("sum123", 32'h40C0_0000, 32'd3, 1'b0, 1'b0);

      beat(32'h3F80_0000, 1'b0);
      beat(32'hBF80_0000, 1'b1);
      finish_pkt("cancel", 32'h0000_0000, 32'd2, 1'b0, 1'b0);

      beat(32'h8000_0000, 1'b1);
      finish_pkt("negzero", 32'h8000_0000, 32'd1, 1'b0, 1'b0);

      beat(32'h3F80_0000, 1'b0);
      beat(32'h3380_0000, 1'b1);
      finish_pkt("rnd_tie_even", 32'h3F80_0000, 32'd2, 1'b0, 1'b0);

      beat(32'h3F80_0000, 1'b0);
      beat(32'h3380_0001, 1'b1);
      finish_pkt("rnd_up", 32'h3F80_0001, 32'd2, 1'b0, 1'b0);

      beat(32'h7FC0_0000, 1'b0);
      beat(32'h3F80_0000, 1'b1);
      check("nan_exp", {24'd0, out_sum[30:23]}, 32'h0000_00FF);
      check("nan_frac_nz", 32'(out_sum[22:0] != 23'd0), 32'd1);
      finish_pkt("nan", 32'h7FC0_0000, 32'd2, 1'b0, 1'b1);

      beat(32'h7F7F_FFFF, 1'b0);
      beat(32'h7F7F_FFFF, 1'b1);
      finish_pkt("overflow", 32'h7F80_0000, 32'd2, 1'b1, 1'b1);

      beat(32'h3F80_0000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h4000_0000;
         in_last  = 1'b1;
         @(posedge clk);
         #1;
         check("bp_sum", out_sum, 32'h3F80_0000);
         check("bp_count", 32'(out_count), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      finish_pkt("bp_first", 32'h3F80_0000, 32'd1, 1'b0, 1'b0);
      beat(32'h4000_0000, 1'b1);
      finish_pkt("bp_next", 32'h4000_0000, 32'd1, 1'b0, 1'b0);

      beat(32'h3F80_0000, 1'b0);
      beat(32'h3F80_0000, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_count", 32'(out_count), 32'd0);
      check("midrst_sum", out_sum, 32'd0);
      #1;
      rst_n = 1'b1;
      beat(32'h4040_0000, 1'b1);
      finish_pkt("midrst_next", 32'h4040_0000, 32'd1, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) begin
         v2 = 1'b1;
         d2 = 32'h3F80_0000;
         l2 = (i == 4);
         @(posedge clk);
         #1;
      end
      v2 = 1'b0;
      l2 = 1'b0;
      check("sat_valid", 32'(ov2_valid), 32'd1);
      check("sat_count", 32'(cnt2), 32'd3);
      check("sat_sum", sum2, 32'h40A0_0000);
      r2 = 1'b1;
      @(posedge clk);
      #1;
      r2 = 1'b0;
      check("sat_released", 32'(rdy2), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
